// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Synchronised input, 3-sample majority vote per bit, parity/framing/break/overrun flags.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_s,
  input  logic                 i_rd_ack,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_A   = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_B   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] DECIDE  = CNT_W'((CLKS_PER_BIT - 1) / 2 + 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE, WAIT_HIGH
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shadow_q, shadow_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 decide;
  logic                 vote;
  logic                 dv;
  logic                 brk;

  assign rx_s   = sync_q[1];
  assign decide = (cnt_q == DECIDE);
  assign vote   = majority3(samp_q[0], samp_q[1], rx_s);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    samp_d    = samp_q;
    shadow_d  = shadow_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    rx_byte_d = rx_byte_q;

    if (cnt_q == SMP_A) samp_d[0] = rx_s;
    if (cnt_q == SMP_B) samp_d[1] = rx_s;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (decide) begin
          if (vote) begin
            // Start bit did not survive the vote: treat as a glitch
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shadow_d = {vote, shadow_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = PAR_EN ? PAR : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (decide) begin
          par_bit_d = vote;
          perr_d    = ((^shadow_q) ^ vote) != PAR_ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (!vote) ferr_d = 1'b1;
          if (bit_idx_q == LAST_STOP) begin
            state_d   = DONE;
            rx_byte_d = shadow_q;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = ferr_q ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        // A held-low line must go high before another start bit is accepted
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dv  = (state_q == DONE);
  assign brk = ferr_q && (shadow_q == '0) && (!PAR_EN || !par_bit_q);

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (i_rd_ack) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (dv) begin
      pending_d = 1'b1;
      if (pending_q && !i_rd_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_byte_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_rx_s};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      rx_byte_q <= rx_byte_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    samp_q    <= samp_d;
    shadow_q  <= shadow_d;
    par_bit_q <= par_bit_d;
  end

  assign o_rx_dv      = dv;
  assign o_rx_byte    = rx_byte_q;
  assign o_parity_err = dv & perr_q;
  assign o_frame_err  = dv & ferr_q;
  assign o_break      = dv & brk;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != IDLE);

endmodule
